// File: rtl/wb_port_scheduler_pkg.sv
// Shared types and defaults for the write-back port scheduler and its result buffer.
package wb_port_scheduler_pkg;

    localparam int unsigned WB_DEPTH        = 2;
    localparam int unsigned WB_STARVE_LIMIT = 4;
    localparam int unsigned WB_CNT_W        = 2;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_STARVING = 2'd1,
        ST_FORCE    = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] value;
    } wb_entry_t;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding long-latency results awaiting a write-port slot.
module wb_result_fifo
    import wb_port_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  wb_entry_t           push_data_i,
    input  logic                pop_i,
    output wb_entry_t           head_o,
    output logic [WB_CNT_W-1:0] count_o
);

    localparam int unsigned         PW      = bits_for(DEPTH);
    localparam logic [WB_CNT_W-1:0] DEPTH_C = WB_CNT_W'(DEPTH);
    localparam logic [PW-1:0]       LAST_C  = PW'(DEPTH - 1);

    wb_entry_t           mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WB_CNT_W-1:0] count_q, count_d;
    logic                do_push, do_pop;

    // Pointer and occupancy update; overflow and underflow requests are ignored
    always_comb begin
        do_push  = push_i && (count_q != DEPTH_C);
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; reset discards any buffered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_scheduler.sv
// Shares the single register-file write port between the pipeline WB stage
// (always wins) and buffered long-latency results; tracks pending writes for
// ID hazards and forces a front-end stall when buffered results starve.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT,
    parameter int unsigned DEPTH        = WB_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_wb_en,
    input  logic [3:0]          pipe_wb_dest,
    input  logic [31:0]         pipe_wb_value,
    input  logic                lu_valid,
    input  logic [3:0]          lu_dest,
    input  logic [31:0]         lu_value,
    output logic                lu_ready,
    input  logic                issue_en,
    input  logic [3:0]          issue_dest,
    input  logic [3:0]          id_src1,
    input  logic [3:0]          id_src2,
    input  logic [3:0]          id_dest,
    input  logic                id_two_src,
    input  logic                id_wb_en,
    output logic                rf_wb_en,
    output logic [3:0]          rf_wb_dest,
    output logic [31:0]         rf_wb_value,
    output logic                lu_hazard,
    output logic                stall_req,
    output logic [15:0]         busy_vec,
    output logic [WB_CNT_W-1:0] buf_count
);

    localparam int unsigned         SW      = bits_for(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]       LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [WB_CNT_W-1:0] DEPTH_C = WB_CNT_W'(DEPTH);

    wb_entry_t           push_entry;
    wb_entry_t           head;
    logic [WB_CNT_W-1:0] count;
    logic [WB_CNT_W-1:0] count_nxt;
    logic                push, pop, full, blocked_full;
    logic [15:0]         busy_q, busy_d;
    sched_state_e        state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d, starve_inc;
    logic                stall_q;

    assign push_entry   = '{dest: lu_dest, value: lu_value};
    assign lu_ready     = (count < DEPTH_C);
    assign push         = lu_valid && lu_ready;
    assign pop          = !pipe_wb_en && (count != '0);
    assign full         = (count == DEPTH_C);
    assign blocked_full = full && pipe_wb_en;
    assign count_nxt    = count + WB_CNT_W'(push) - WB_CNT_W'(pop);
    assign starve_inc   = (starve_q == '1) ? starve_q : starve_q + 1'b1;

    wb_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    // Write-port arbitration: pipeline first, otherwise drain the buffer head
    always_comb begin
        rf_wb_en    = 1'b0;
        rf_wb_dest  = '0;
        rf_wb_value = '0;
        if (pipe_wb_en) begin
            rf_wb_en    = 1'b1;
            rf_wb_dest  = pipe_wb_dest;
            rf_wb_value = pipe_wb_value;
        end else if (count != '0) begin
            rf_wb_en    = 1'b1;
            rf_wb_dest  = head.dest;
            rf_wb_value = head.value;
        end
    end

    // Pending-write scoreboard; a new issue overrides a same-cycle commit
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.dest] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    assign lu_hazard = busy_q[id_src1]
                     | (id_two_src & busy_q[id_src2])
                     | (id_wb_en   & busy_q[id_dest])
                     | (issue_en   & busy_q[issue_dest]);

    // Starvation FSM next-state: count blocked cycles at full, stall until drained
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (blocked_full) begin
                    starve_d = SW'(1);
                    state_d  = (STARVE_LIMIT <= 1) ? ST_FORCE : ST_STARVING;
                end
            end
            ST_STARVING: begin
                if (pop) begin
                    state_d  = ST_NORMAL;
                    starve_d = '0;
                end else if (blocked_full) begin
                    starve_d = starve_inc;
                    if (starve_inc >= LIMIT_C) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (count_nxt == '0) begin
                    state_d  = ST_NORMAL;
                    starve_d = '0;
                end
            end
            default: begin
                state_d  = ST_NORMAL;
                starve_d = '0;
            end
        endcase
    end

    // Registered scheduler state; stall_req is a flop tracking the FORCE state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            busy_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            stall_q  <= (state_d == ST_FORCE);
        end
    end

    assign stall_req = stall_q;
    assign busy_vec  = busy_q;
    assign buf_count = count;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler with a scoreboard of buffered results.
module tb_wb_port_scheduler;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        pipe_wb_en;
    logic [3:0]  pipe_wb_dest;
    logic [31:0] pipe_wb_value;
    logic        lu_valid;
    logic [3:0]  lu_dest;
    logic [31:0] lu_value;
    logic        lu_ready;
    logic        issue_en;
    logic [3:0]  issue_dest;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        id_two_src, id_wb_en;
    logic        rf_wb_en;
    logic [3:0]  rf_wb_dest;
    logic [31:0] rf_wb_value;
    logic        lu_hazard;
    logic        stall_req;
    logic [15:0] busy_vec;
    logic [1:0]  buf_count;

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mbusy;
    logic        exp_stall;
    int          checks = 0;
    int          errors = 0;

    wb_port_scheduler #(
        .STARVE_LIMIT(4),
        .DEPTH       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_dest (pipe_wb_dest),
        .pipe_wb_value(pipe_wb_value),
        .lu_valid     (lu_valid),
        .lu_dest      (lu_dest),
        .lu_value     (lu_value),
        .lu_ready     (lu_ready),
        .issue_en     (issue_en),
        .issue_dest   (issue_dest),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_dest      (id_dest),
        .id_two_src   (id_two_src),
        .id_wb_en     (id_wb_en),
        .rf_wb_en     (rf_wb_en),
        .rf_wb_dest   (rf_wb_dest),
        .rf_wb_value  (rf_wb_value),
        .lu_hazard    (lu_hazard),
        .stall_req    (stall_req),
        .busy_vec     (busy_vec),
        .buf_count    (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pipe_wb_en    = 1'b0;
        pipe_wb_dest  = '0;
        pipe_wb_value = '0;
        lu_valid      = 1'b0;
        lu_dest       = '0;
        lu_value      = '0;
        issue_en      = 1'b0;
        issue_dest    = '0;
        id_src1       = '0;
        id_src2       = '0;
        id_dest       = '0;
        id_two_src    = 1'b0;
        id_wb_en      = 1'b0;
    endtask

    task automatic pipe(input logic [3:0] d, input logic [31:0] v);
        pipe_wb_en    = 1'b1;
        pipe_wb_dest  = d;
        pipe_wb_value = v;
    endtask

    task automatic lu(input logic [3:0] d, input logic [31:0] v);
        lu_valid = 1'b1;
        lu_dest  = d;
        lu_value = v;
    endtask

    task automatic issue(input logic [3:0] d);
        issue_en   = 1'b1;
        issue_dest = d;
    endtask

    // Entered at posedge+1 with inputs driven: compare late in the cycle,
    // advance the model across the edge, return at the next posedge+1.
    task automatic step();
        int   sz;
        logic acc;
        logic exp_en;
        logic exp_haz;
        #3;
        sz     = mq.size();
        acc    = lu_valid && (sz < DEPTH);
        exp_en = pipe_wb_en || (sz != 0);
        chk("rf_wb_en", rf_wb_en, exp_en);
        if (pipe_wb_en) begin
            chk("rf_wb_dest_pipe", rf_wb_dest, pipe_wb_dest);
            chk("rf_wb_value_pipe", rf_wb_value, pipe_wb_value);
        end else if (sz != 0) begin
            chk("rf_wb_dest_buf", rf_wb_dest, mq[0].d);
            chk("rf_wb_value_buf", rf_wb_value, mq[0].v);
        end
        chk("buf_count", buf_count, sz);
        chk("lu_ready", lu_ready, sz < DEPTH);
        chk("busy_vec", busy_vec, mbusy);
        exp_haz = mbusy[id_src1] | (id_two_src & mbusy[id_src2])
                | (id_wb_en & mbusy[id_dest]) | (issue_en & mbusy[issue_dest]);
        chk("lu_hazard", lu_hazard, exp_haz);
        chk("stall_req", stall_req, exp_stall);
        if (!pipe_wb_en && sz != 0) begin
            mbusy[mq[0].d] = 1'b0;
            void'(mq.pop_front());
        end
        if (issue_en) mbusy[issue_dest] = 1'b1;
        if (acc) mq.push_back('{d: lu_dest, v: lu_value});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mbusy     = '0;
        exp_stall = 1'b0;
        idle();

        // Reset state and write-port passthrough while in reset
        repeat (2) @(posedge clk);
        #1;
        pipe(4'd2, 32'h55);
        #3;
        chk("rst_buf_count", buf_count, 0);
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_rf_en", rf_wb_en, 1);
        chk("rst_rf_dest", rf_wb_dest, 2);
        chk("rst_rf_value", rf_wb_value, 32'h55);
        @(posedge clk);
        #1;
        idle();
        #3;
        chk("rst_rf_idle", rf_wb_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Issue r5, result three cycles later, commit the following cycle
        idle(); issue(4'd5);                       step();
        idle(); id_src1 = 4'd5;                    step();
        idle(); issue(4'd5);                       step();
        idle(); lu(4'd5, 32'hDEADBEEF);            step();
        idle(); id_src1 = 4'd5;                    step();
        idle(); id_src1 = 4'd5;                    step();

        // Pipeline write pre-empts a buffered entry, which commits afterwards
        idle(); issue(4'd6);                       step();
        idle(); lu(4'd6, 32'h66);                  step();
        idle(); pipe(4'd3, 32'h11);                step();
        idle();                                    step();
        idle();                                    step();

        // Hazard terms qualified by id_two_src and id_wb_en
        idle(); issue(4'd7);                       step();
        idle(); id_src2 = 4'd7; id_src1 = 4'd1;    step();
        idle(); id_src2 = 4'd7; id_two_src = 1'b1; step();
        idle(); id_dest = 4'd7;                    step();
        idle(); id_dest = 4'd7; id_wb_en = 1'b1;   step();
        idle(); lu(4'd7, 32'h77);                  step();
        idle();                                    step();

        // Re-issue of r9 in the cycle its previous result commits keeps it busy
        idle(); issue(4'd9);                       step();
        idle(); lu(4'd9, 32'h99);                  step();
        idle(); issue(4'd9);                       step();
        idle();                                    step();
        idle(); lu(4'd9, 32'h999);                 step();
        idle();                                    step();
        idle();                                    step();

        // Starvation: full buffer blocked four cycles forces a stall until drained
        idle(); pipe(4'd1, 32'hA1); lu(4'd10, 32'hA);  step();
        idle(); pipe(4'd1, 32'hA2); lu(4'd11, 32'hB);  step();
        for (int i = 0; i < 4; i++) begin
            idle(); pipe(4'd2, 32'hB0 + i);        step();
        end
        exp_stall = 1'b1;
        idle();                                    step();
        idle();                                    step();
        exp_stall = 1'b0;
        idle();                                    step();
        idle();                                    step();

        // Reach FORCE with a full buffer and pending writes, then reset mid-cycle
        idle(); pipe(4'd4, 32'h44); issue(4'd12);                       step();
        idle(); pipe(4'd4, 32'h45); issue(4'd13); lu(4'd12, 32'hC12);   step();
        idle(); pipe(4'd4, 32'h46); lu(4'd13, 32'hC13);                 step();
        for (int i = 0; i < 4; i++) begin
            idle(); pipe(4'd4, 32'h50 + i);        step();
        end
        exp_stall = 1'b1;
        idle(); pipe(4'd4, 32'h60);                step();
        idle(); pipe(4'd8, 32'h88);
        #1;
        chk("pre_rst_count", buf_count, 2);
        chk("pre_rst_stall", stall_req, 1);
        chk("pre_rst_busy", busy_vec, 16'h3000);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", buf_count, 0);
        chk("mid_rst_stall", stall_req, 0);
        chk("mid_rst_busy", busy_vec, 0);
        chk("mid_rst_lu_ready", lu_ready, 1);
        chk("mid_rst_rf_dest", rf_wb_dest, 8);
        chk("mid_rst_rf_value", rf_wb_value, 32'h88);
        mq.delete();
        mbusy     = '0;
        exp_stall = 1'b0;
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
        idle();                                    step();
        idle(); lu(4'd14, 32'hE);                  step();
        idle();                                    step();
        idle();                                    step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
